fifo_read_ctrl: RTL

Read-side controller for the team's dual-clock FIFO, the counterpart of the write-side memory and write logic. It owns the read pointer in the rclk domain, generates the memory read address, and produces a Gray-coded read pointer for synchronisation back to the write domain. It computes empty from the write pointer that has already been synchronised into rclk. It also presents popped data through a registered valid/ready output stage and reports occupancy.

---
 rtl/fifo_read_ctrl.sv | 48 ++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side pointer, empty/level tracking and registered output stage of a dual-clock FIFO.
module fifo_read_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [ADDR_SIZE:0]   rlevel
);
  logic [ADDR_SIZE:0] rbin, rbinnext, rgraynext, wbin;
  logic pop;
  assign raddr = rbin[ADDR_SIZE-1:0];
  assign pop = !rempty && (!dout_valid || dout_ready);
  assign rbinnext = rbin + (ADDR_SIZE+1)'(pop);
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  // each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) wbin[i] = ^(rq2_wptr >> i);
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
      rempty <= 1'b1;
      dout <= '0;
      dout_valid <= 1'b0;
      rlevel <= '0;
    end else begin
      rbin <= rbinnext;
      rptr <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
      rlevel <= wbin - rbinnext;
      if (pop) begin
        dout <= rdata;
        dout_valid <= 1'b1;
      end else if (dout_ready) dout_valid <= 1'b0;
    end
  end
endmodule
